// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
//
// Handshake: req[i] is a level. Client i keeps it high for as long as it
// wants the resource and drops it to give the resource back. gnt is one-hot
// or zero and is driven only from registers. While gnt[i]=1, client i owns the
// resource. A request that is dropped before it is granted is forgotten.
// There is no valid/ready pairing beyond this req-level / gnt-level protocol.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_any;
  logic       busy;

  // Client side: raises requests and observes grants.
  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_any,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_any,
    output busy
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time and a single
// dead cycle between owners. Every output comes straight from a flop or from
// a decode of flops, so there is no combinational path from req.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,  // legal range 2..15
  parameter int CW       = 4   // 2**CW must exceed MAX_HOLD
) (
  input  logic         clk,
  input  logic         reset,
  rr_arbiter4_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DEAD  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state, nxt_state;
  logic [1:0]    ptr, nxt_ptr;
  logic [1:0]    owner, nxt_owner;
  logic [CW-1:0] hold_cnt, nxt_hold;
  logic [3:0]    gnt_r, nxt_gnt;
  logic [1:0]    win;
  logic          win_found;

  // Winner search: first requesting index in the order ptr, ptr+1, ptr+2, ptr+3.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    win       = ptr;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!win_found && bus.req[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  // State register; reset is asynchronous so it cuts a grant short immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      hold_cnt <= '0;
      gnt_r    <= 4'd0;
    end else begin
      state    <= nxt_state;
      ptr      <= nxt_ptr;
      owner    <= nxt_owner;
      hold_cnt <= nxt_hold;
      gnt_r    <= nxt_gnt;
    end
  end

  // Next-state logic: arbitrate in IDLE, count hold cycles in GRANT, and
  // always pass through DEAD for one cycle between owners.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_owner = owner;
    nxt_hold  = hold_cnt;
    nxt_gnt   = gnt_r;
    case (state)
      IDLE: begin
        nxt_gnt   = 4'd0;
        nxt_owner = 2'd0;
        if (win_found) begin
          nxt_state = GRANT;
          nxt_owner = win;
          nxt_hold  = '0;
          nxt_gnt   = 4'b0001 << win;
        end
      end
      GRANT: begin
        // Release and expiry share one path; an expired owner that still
        // requests simply competes again with the lowest priority.
        if (bus.req[owner] && (hold_cnt < HOLD_LAST)) begin
          nxt_hold = hold_cnt + CW'(1);
        end else begin
          nxt_state = DEAD;
          nxt_ptr   = owner + 2'd1;
          nxt_owner = 2'd0;
          nxt_hold  = '0;
          nxt_gnt   = 4'd0;
        end
      end
      DEAD: begin
        nxt_state = IDLE;
        nxt_gnt   = 4'd0;
        nxt_owner = 2'd0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_ptr   = 2'd0;
        nxt_owner = 2'd0;
        nxt_hold  = '0;
        nxt_gnt   = 4'd0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    bus.gnt     = gnt_r;
    bus.gnt_id  = owner;
    bus.gnt_any = |gnt_r;
    bus.busy    = (state != IDLE);
    state_dbg   = state;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single client, fairness, asynchronous
// reset mid-grant, hold expiry with pointer wrap and full round robin, plus
// per-cycle invariant checks.
module tb_rr_arbiter4;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         pass_cnt;
  int         total_cnt;
  logic [3:0] prev_gnt;
  logic [1:0] exp_q[$];

  rr_arbiter4_if bus();

  rr_arbiter4 #(.MAX_HOLD(8), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic any, input logic bsy);
    chk({tag, ".gnt"},     bus.gnt,     g);
    chk({tag, ".gnt_id"},  bus.gnt_id,  id);
    chk({tag, ".gnt_any"}, bus.gnt_any, any);
    chk({tag, ".busy"},    bus.busy,    bsy);
  endtask

  // Model of a continuously requested stretch starting from IDLE:
  // 8 grant cycles, 1 DEAD cycle, 1 IDLE cycle, repeating.
  function automatic logic [3:0] rr_exp_gnt(input int c, input logic [3:0] first_owner_oh,
                                            input bit rotate);
    int pos;
    int slot;
    logic [3:0] oh;
    pos  = (c - 1) % 10;
    slot = (c - 1) / 10;
    oh   = first_owner_oh;
    if (rotate) oh = 4'b0001 << (slot % 4);
    return (pos < 8) ? oh : 4'd0;
  endfunction

  // Invariants sampled on the falling edge every cycle.
  always @(negedge clk) begin
    logic [1:0] enc;
    enc = 2'd0;
    for (int i = 0; i < 4; i++) if (bus.gnt[i]) enc = 2'(i);
    chk("inv.onehot0", $onehot0(bus.gnt), 1'b1);
    chk("inv.gnt_any", bus.gnt_any, |bus.gnt);
    if (bus.gnt_any) chk("inv.gnt_id", bus.gnt_id, enc);
    if ((prev_gnt != 4'd0) && (bus.gnt != 4'd0)) chk("inv.adjacent", bus.gnt, prev_gnt);
    prev_gnt = bus.gnt;
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    prev_gnt  = 4'd0;
    reset     = 1'b1;
    bus.req   = 4'd0;

    // Reset state
    #1;
    chk_out("reset", 4'd0, 2'd0, 1'b0, 1'b0);
    chk("reset.state", state_dbg, 2'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk_out("idle", 4'd0, 2'd0, 1'b0, 1'b0);

    // Single client: 3 grant cycles, DEAD, IDLE. Leaves ptr=2.
    bus.req = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk_out($sformatf("single.c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    bus.req = 4'b0000;
    step();
    chk_out("single.dead", 4'd0, 2'd0, 1'b0, 1'b1);
    chk("single.dead.state", state_dbg, 2'd2);
    step();
    chk_out("single.idle", 4'd0, 2'd0, 1'b0, 1'b0);

    // Fairness: owner 2 releases, then req=0101 -> search 3,0,.. picks 0.
    bus.req = 4'b0100;
    step();
    chk_out("fair.own2", 4'b0100, 2'd2, 1'b1, 1'b1);
    bus.req = 4'b0001;
    step();
    chk_out("fair.dead", 4'd0, 2'd0, 1'b0, 1'b1);
    bus.req = 4'b0101;
    step();
    chk_out("fair.idle", 4'd0, 2'd0, 1'b0, 1'b0);
    step();
    chk_out("fair.next", 4'b0001, 2'd0, 1'b1, 1'b1);
    bus.req = 4'b0000;
    step();
    step();
    chk_out("fair.end", 4'd0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant. ptr is 1 here, so 0100 wins.
    bus.req = 4'b0100;
    step();
    chk_out("arst.pre", 4'b0100, 2'd2, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("arst.now", 4'd0, 2'd0, 1'b0, 1'b0);
    chk("arst.state", state_dbg, 2'd0);
    step();
    // With ptr restarted at 0, req=1001 must pick client 0 (ptr=1 would pick 3).
    reset   = 1'b0;
    bus.req = 4'b1001;
    step();
    chk_out("arst.ptr0", 4'b0001, 2'd0, 1'b1, 1'b1);
    bus.req = 4'b0000;
    step();
    step();
    chk_out("arst.end", 4'd0, 2'd0, 1'b0, 1'b0);

    // Lone requester 3 for 20 cycles: expiry, 2-cycle gap, regrant.
    bus.req = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      logic [3:0] eg;
      step();
      eg = rr_exp_gnt(c, 4'b1000, 1'b0);
      chk($sformatf("lone.c%0d.gnt", c), bus.gnt, eg);
      chk($sformatf("lone.c%0d.busy", c), bus.busy, ((c - 1) % 10) != 9);
    end

    // Both expiries of owner 3 wrapped ptr to 0, so round robin starts at 0.
    bus.req = 4'b1111;
    exp_q   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    begin
      logic [3:0] last_g;
      last_g = 4'd0;
      for (int c = 1; c <= 48; c++) begin
        logic [3:0] eg;
        step();
        eg = rr_exp_gnt(c, 4'd0, 1'b1);
        chk($sformatf("rr.c%0d.gnt", c), bus.gnt, eg);
        chk($sformatf("rr.c%0d.busy", c), bus.busy, ((c - 1) % 10) != 9);
        if ((bus.gnt != 4'd0) && (last_g == 4'd0)) begin
          if (exp_q.size() == 0) chk("rr.sb.extra_grant", bus.gnt, 4'd0);
          else chk("rr.sb.order", bus.gnt_id, exp_q.pop_front());
        end
        last_g = bus.gnt;
      end
    end
    chk("rr.sb.left", exp_q.size(), 0);
    bus.req = 4'b0000;
    step();
    chk_out("rr.dead", 4'd0, 2'd0, 1'b0, 1'b1);
    step();
    chk_out("rr.idle", 4'd0, 2'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
